j1_io_uart: RTL and testbench
=============================

J1_IO_UART -- requirements
Module: j1_io_uart

Interface
REQ-001 SHALL provide parameter CLKDIV_RESET, default 16'd104, reset value of the baud divisor (12 MHz / 115200).
REQ-002 SHALL provide parameter SELBIT, default 12, the io_addr bit that selects this block.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 resetq  input  1  reset, asynchronous, active-low.
REQ-005 io_rd  input  1  CPU IO read strobe, single cycle.
REQ-006 io_wr  input  1  CPU IO write strobe, single cycle.
REQ-007 io_addr  input  32  CPU IO address; decode uses io_addr[SELBIT] and io_addr[3:2].
REQ-008 io_dout  input  32  CPU write data.
REQ-009 io_din  output  32  registered read data to CPU.
REQ-010 uart_rx  input  1  asynchronous serial input, idle high.
REQ-011 uart_tx  output  1  serial output, idle high.
REQ-012 interrupt_request  output  1  registered level interrupt to CPU.

Function
REQ-013 Block SHALL be selected when io_addr[SELBIT]=1; register select = io_addr[3:2]: 0 DATA, 1 STATUS, 2 DIV, 3 IE.
REQ-014 io_din SHALL load on the clock edge where io_rd and select are high, and hold until the next selected read; the CPU consumes it from the next instruction.
REQ-015 DATA read: io_din = {23'b0, valid, byte}; non-empty -> oldest RX byte, valid=1, RX FIFO pops on the same edge; empty -> 32'h0, no pointer change.
REQ-016 STATUS read: bit0 tx_busy, bit1 rx_nonempty, bit2 rx_full, bit3 overrun, bit4 framing_err, bits[12:8] rx count (0..depth), others 0; read clears bit3 and bit4 on the same edge.
REQ-017 DIV: 16-bit, write loads io_dout[15:0], read returns it zero-extended; bit period = max(DIV,2) clocks.
REQ-018 IE: 2-bit, bit0 rx interrupt enable, bit1 tx-idle interrupt enable.
REQ-019 DATA write while TX idle SHALL start a frame with io_dout[7:0]; while tx_busy SHALL be ignored.
REQ-020 TX FSM states IDLE, START, DATA (8 bits, LSB first), STOP; each state lasts one bit period; tx_busy=1 from the edge after the write until STOP completes.
REQ-021 uart_rx SHALL pass a 2-flop synchronizer before use.
REQ-022 RX FSM states IDLE, START, DATA, STOP: falling edge in IDLE -> START; sample at DIV/2 (floor) clocks; start bit high at sample -> IDLE, nothing recorded; data sampled at one-bit-period intervals thereafter.
REQ-023 Stop bit sampled 0 -> framing_err sticky set, byte discarded; sampled 1 -> byte pushed to RX FIFO.
REQ-024 Push when FIFO full -> byte discarded, overrun sticky set, unless a pop occurs on the same edge, in which case push is accepted.
REQ-025 Pointers SHALL wrap modulo depth; count SHALL distinguish full from empty.
REQ-026 interrupt_request SHALL register (IE[0] & rx_nonempty) | (IE[1] & ~tx_busy), one clock after its cause.
REQ-027 Unselected strobes SHALL cause no state change and leave io_din unchanged.
REQ-028 DIV write during an active frame SHALL take effect from the next bit period boundary of each FSM.

Reset
REQ-029 On resetq low, asynchronously: uart_tx=1, io_din=0, interrupt_request=0, DIV=CLKDIV_RESET, IE=0, FIFO empty, sticky flags 0, both FSMs IDLE.
REQ-030 Reset mid-frame SHALL abort the frame; after release, TX stays idle and RX waits for a fresh falling edge.

Configuration
REQ-031 Macro UART_RX_FIFO_EN defined: RX buffer is a 16-entry FIFO, count field 0..16.
REQ-032 Macro UART_RX_FIFO_EN undefined: RX buffer is a single holding register (depth 1), rx_full == rx_nonempty, count 0..1; all other behaviour unchanged.

Verification
REQ-033 Reset, DIV=104: write DATA 32'h55 -> uart_tx low for 104 clocks, then 1,0,1,0,1,0,1,0, then high; tx_busy 1 throughout.
REQ-034 Drive 0xA3 8N1 at DIV=104 on uart_rx, IE=1 -> interrupt_request high; DATA read -> io_din=32'h1A3; interrupt_request low one clock after pop.
REQ-035 With FIFO enabled, send 17 bytes, no reads -> STATUS count=16, overrun=1; read STATUS again -> overrun=0.
REQ-036 Frame with stop bit 0 -> framing_err=1, count unchanged; 3-clock low glitch on uart_rx -> no byte, no flag.
REQ-037 Write DATA 0x41 then 0x42 during the frame -> only 0x41 transmitted; DATA read while empty -> io_din=32'h0.
REQ-038 Assert resetq low mid-TX frame -> uart_tx=1 immediately, tx_busy=0 after release.

Source files
------------

// File: rtl/j1_io_uart.sv
// J1 CPU memory-mapped UART: DATA/STATUS/DIV/IE registers, 8N1 TX and RX with an RX buffer.
// Define UART_RX_FIFO_EN for a 16-entry RX FIFO; otherwise the RX buffer is a single holding register.
module j1_io_uart #(
  parameter logic [15:0] CLKDIV_RESET = 16'd104,
  parameter int          SELBIT       = 12
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_dout,
  output logic [31:0] io_din,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        interrupt_request
);

`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 1;
`endif
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_IE     = 2'd3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [15:0] div;
  logic [1:0]  ie;
  logic        overrun;
  logic        framing_err;
  logic [4:0]  count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [7:0]  mem [DEPTH];

  logic        sel;
  logic [1:0]  reg_sel;
  logic        rd_en;
  logic        wr_en;
  logic [15:0] period;
  logic        unused_bits;

  assign sel         = io_addr[SELBIT];
  assign reg_sel     = io_addr[3:2];
  assign rd_en       = io_rd & sel;
  assign wr_en       = io_wr & sel;
  assign period      = (div < 16'd2) ? 16'd2 : div;
  assign unused_bits = ^{io_addr, io_dout};

  // ---------------- transmitter ----------------
  tx_state_t   tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [15:0] tx_per, tx_per_n;
  logic [2:0]  tx_idx, tx_idx_n;
  logic [7:0]  tx_data, tx_data_n;
  logic        tx_line_n;
  logic        tx_busy;
  logic        tx_bit_end;

  assign tx_busy    = (tx_state != TX_IDLE);
  assign tx_bit_end = (tx_cnt == tx_per - 16'd1);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_per   <= 16'd2;
      tx_idx   <= '0;
      tx_data  <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_per   <= tx_per_n;
      tx_idx   <= tx_idx_n;
      tx_data  <= tx_data_n;
      uart_tx  <= tx_line_n;
    end
  end

  // The bit period is re-latched at every boundary so DIV changes apply to the next bit.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 16'd1;
    tx_per_n   = tx_per;
    tx_idx_n   = tx_idx;
    tx_data_n  = tx_data;
    tx_line_n  = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        if (wr_en && reg_sel == REG_DATA) begin
          tx_state_n = TX_START;
          tx_per_n   = period;
          tx_idx_n   = '0;
          tx_data_n  = io_dout[7:0];
        end
      end
      TX_START: if (tx_bit_end) begin
        tx_state_n = TX_DATA;
        tx_cnt_n   = '0;
        tx_per_n   = period;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_cnt_n = '0;
        tx_per_n = period;
        if (tx_idx == 3'd7) tx_state_n = TX_STOP;
        else                tx_idx_n   = tx_idx + 3'd1;
      end
      TX_STOP: if (tx_bit_end) begin
        tx_state_n = TX_IDLE;
        tx_cnt_n   = '0;
      end
      default: tx_state_n = TX_IDLE;
    endcase
    case (tx_state_n)
      TX_START: tx_line_n = 1'b0;
      TX_DATA:  tx_line_n = tx_data_n[tx_idx_n];
      default:  tx_line_n = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  rx_state_t   rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [15:0] rx_per, rx_per_n;
  logic [2:0]  rx_idx, rx_idx_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_s1, rx_s2, rx_prev;
  logic        push_req;
  logic        frame_set;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_per   <= 16'd2;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_per   <= rx_per_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
    end
  end

  // Start bit is checked half a period after the falling edge; later samples are a full period apart.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 16'd1;
    rx_per_n   = rx_per;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    push_req   = 1'b0;
    frame_set  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_s2) begin
          rx_state_n = RX_START;
          rx_per_n   = period;
        end
      end
      RX_START: if (rx_cnt == {1'b0, rx_per[15:1]} - 16'd1) begin
        rx_cnt_n   = '0;
        rx_per_n   = period;
        rx_idx_n   = '0;
        rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == rx_per - 16'd1) begin
        rx_cnt_n   = '0;
        rx_per_n   = period;
        rx_shift_n = {rx_s2, rx_shift[7:1]};
        if (rx_idx == 3'd7) rx_state_n = RX_STOP;
        else                rx_idx_n   = rx_idx + 3'd1;
      end
      RX_STOP: if (rx_cnt == rx_per - 16'd1) begin
        rx_cnt_n   = '0;
        rx_state_n = RX_IDLE;
        push_req   = rx_s2;
        frame_set  = !rx_s2;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- RX buffer and CPU registers ----------------
  logic        nonempty;
  logic        full;
  logic        pop;
  logic        push_ok;
  logic        stat_rd;
  logic [4:0]  count_n;
  logic [31:0] rd_data;

  assign nonempty = (count != 5'd0);
  assign full     = (count == 5'(DEPTH));
  assign pop      = rd_en && (reg_sel == REG_DATA) && nonempty;
  assign push_ok  = push_req && (!full || pop);
  assign stat_rd  = rd_en && (reg_sel == REG_STATUS);
  assign count_n  = count + {4'b0, push_ok} - {4'b0, pop};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_DATA:   if (nonempty) rd_data = {23'b0, 1'b1, mem[rd_ptr]};
      REG_STATUS: rd_data = {19'b0, count, 3'b0, framing_err, overrun, full, nonempty, tx_busy};
      REG_DIV:    rd_data = {16'b0, div};
      default:    rd_data = {30'b0, ie};
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_shift;
  end

  // A flag being set on the same edge as a STATUS read wins, so no error event is lost.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      io_din            <= '0;
      div               <= CLKDIV_RESET;
      ie                <= '0;
      overrun           <= 1'b0;
      framing_err       <= 1'b0;
      count             <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      interrupt_request <= 1'b0;
    end else begin
      if (rd_en) io_din <= rd_data;
      if (wr_en && reg_sel == REG_DIV) div <= io_dout[15:0];
      if (wr_en && reg_sel == REG_IE)  ie  <= io_dout[1:0];
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      count <= count_n;
      if (push_req && full && !pop) overrun <= 1'b1;
      else if (stat_rd)             overrun <= 1'b0;
      if (frame_set)    framing_err <= 1'b1;
      else if (stat_rd) framing_err <= 1'b0;
      interrupt_request <= (ie[0] & nonempty) | (ie[1] & ~tx_busy);
    end
  end

endmodule

// File: tb/tb_j1_io_uart.sv
// Directed self-checking bench for j1_io_uart; expectations adapt to UART_RX_FIFO_EN.
module tb_j1_io_uart;

`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk;
  logic        resetq;
  logic        io_rd;
  logic        io_wr;
  logic [31:0] io_addr;
  logic [31:0] io_dout;
  logic [31:0] io_din;
  logic        uart_rx;
  logic        uart_tx;
  logic        interrupt_request;

  int checks = 0;
  int errors = 0;

  j1_io_uart dut (
    .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr),
    .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .interrupt_request(interrupt_request)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] addr_of(input logic blk, input logic [1:0] r);
    return (blk ? 32'h0000_1000 : 32'h0) | ({30'b0, r} << 2);
  endfunction

  task automatic cpu_write(input logic blk, input logic [1:0] r, input logic [31:0] d);
    io_addr = addr_of(blk, r);
    io_dout = d;
    io_wr   = 1'b1;
    @(negedge clk);
    io_wr   = 1'b0;
  endtask

  task automatic cpu_read(input logic blk, input logic [1:0] r, output logic [31:0] d);
    io_addr = addr_of(blk, r);
    io_rd   = 1'b1;
    @(negedge clk);
    io_rd   = 1'b0;
    d       = io_din;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int per);
    uart_rx = 1'b0;
    tick(per);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(per);
    end
    uart_rx = stop;
    tick(per);
    uart_rx = 1'b1;
    tick(3);
  endtask

  task automatic capture_tx(input int per, output logic [7:0] b, output logic ok);
    int waited;
    waited = 0;
    ok = 1'b1;
    b = '0;
    while (uart_tx !== 1'b0 && waited < 3000) begin
      tick(1);
      waited++;
    end
    if (uart_tx !== 1'b0) begin
      ok = 1'b0;
    end else begin
      tick(per / 2);
      if (uart_tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick(per);
        b[i] = uart_tx;
      end
      tick(per);
      if (uart_tx !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    checks++;
    if (uart_tx !== 1'b1 || io_din !== 32'h0 || interrupt_request !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_pins: tx=%b din=%h irq=%b, want tx=1 din=0 irq=0", uart_tx, io_din, interrupt_request);
    end
    cpu_read(1'b1, 2'd1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_status: got %h want 00000000", d); end
    cpu_read(1'b1, 2'd2, d);
    checks++;
    if (d !== 32'd104) begin errors++; $display("[TB] FAIL reset_div: got %h want 00000068", d); end
    cpu_read(1'b1, 2'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_ie: got %h want 00000000", d); end
    cpu_read(1'b1, 2'd0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_data_empty: got %h want 00000000", d); end
  endtask

  task automatic test_tx_frame;
    logic [31:0] d;
    logic        exp;
    int          bad;
    logic [7:0]  pat;
    pat = 8'h55;
    cpu_write(1'b1, 2'd0, 32'h55);
    for (int b = 0; b < 10; b++) begin
      if (b == 0)      exp = 1'b0;
      else if (b == 9) exp = 1'b1;
      else             exp = pat[b-1];
      bad = 0;
      for (int i = 0; i < 104; i++) begin
        if (uart_tx !== exp) bad++;
        tick(1);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("[TB] FAIL tx_55_bit%0d: %0d of 104 clocks differ from required level %b", b, bad, exp);
      end
    end
    cpu_read(1'b1, 2'd1, d);
    checks++;
    if (d !== 32'h0 || uart_tx !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tx_55_idle_after: status=%h tx=%b want status=0 tx=1", d, uart_tx);
    end
  endtask

  task automatic test_tx_busy_ignore;
    logic [31:0] d;
    logic [7:0]  b;
    logic        ok;
    int          lows;
    cpu_write(1'b1, 2'd0, 32'h41);
    cpu_write(1'b1, 2'd0, 32'h42);
    cpu_read(1'b1, 2'd1, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("[TB] FAIL tx_busy_status: got %h want 00000001", d); end
    capture_tx(104, b, ok);
    checks++;
    if (!ok || b !== 8'h41) begin
      errors++;
      $display("[TB] FAIL tx_first_byte: got %h framing_ok=%b want 41 framing_ok=1", b, ok);
    end
    tick(60);
    lows = 0;
    for (int i = 0; i < 2200; i++) begin
      if (uart_tx !== 1'b1) lows++;
      tick(1);
    end
    checks++;
    if (lows != 0) begin errors++; $display("[TB] FAIL tx_second_ignored: %0d low clocks, want 0", lows); end
    cpu_read(1'b1, 2'd1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL tx_idle_status: got %h want 00000000", d); end
  endtask

  task automatic test_rx_irq;
    logic [31:0] d;
    cpu_write(1'b1, 2'd3, 32'h1);
    tick(2);
    checks++;
    if (interrupt_request !== 1'b0) begin errors++; $display("[TB] FAIL irq_empty: got %b want 0", interrupt_request); end
    send_rx(8'hA3, 1'b1, 104);
    checks++;
    if (interrupt_request !== 1'b1) begin errors++; $display("[TB] FAIL irq_rx: got %b want 1", interrupt_request); end
    cpu_read(1'b1, 2'd0, d);
    checks++;
    if (d !== 32'h1A3) begin errors++; $display("[TB] FAIL rx_a3_data: got %h want 000001a3", d); end
    checks++;
    if (interrupt_request !== 1'b1) begin errors++; $display("[TB] FAIL irq_pop_edge: got %b want 1", interrupt_request); end
    tick(1);
    checks++;
    if (interrupt_request !== 1'b0) begin errors++; $display("[TB] FAIL irq_after_pop: got %b want 0", interrupt_request); end
    cpu_write(1'b1, 2'd3, 32'h2);
    tick(1);
    checks++;
    if (interrupt_request !== 1'b1) begin errors++; $display("[TB] FAIL irq_tx_idle: got %b want 1", interrupt_request); end
    cpu_write(1'b1, 2'd3, 32'h0);
    tick(1);
    checks++;
    if (interrupt_request !== 1'b0) begin errors++; $display("[TB] FAIL irq_disabled: got %b want 0", interrupt_request); end
  endtask

  task automatic test_div_ie;
    logic [31:0] d;
    logic [19:0] seen;
    cpu_write(1'b1, 2'd2, 32'hABCD_1234);
    cpu_read(1'b1, 2'd2, d);
    checks++;
    if (d !== 32'h0000_1234) begin errors++; $display("[TB] FAIL div_rw: got %h want 00001234", d); end
    cpu_write(1'b1, 2'd3, 32'hFFFF_FFFF);
    cpu_read(1'b1, 2'd3, d);
    checks++;
    if (d !== 32'h3) begin errors++; $display("[TB] FAIL ie_rw: got %h want 00000003", d); end
    cpu_write(1'b1, 2'd3, 32'h0);
    // DIV=1 must still give two clocks per bit.
    cpu_write(1'b1, 2'd2, 32'h1);
    cpu_write(1'b1, 2'd0, 32'h0F);
    for (int i = 0; i < 20; i++) begin
      seen[19-i] = uart_tx;
      tick(1);
    end
    checks++;
    if (seen !== 20'b00_11_11_11_11_00_00_00_00_11) begin
      errors++;
      $display("[TB] FAIL div_min_two: got %b want 00111111110000000011", seen);
    end
    tick(4);
    cpu_read(1'b1, 2'd2, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("[TB] FAIL div_unclamped_read: got %h want 00000001", d); end
    cpu_write(1'b1, 2'd2, 32'h8);
  endtask

  task automatic test_unselected;
    logic [31:0] d;
    int          lows;
    cpu_read(1'b1, 2'd2, d);
    cpu_write(1'b0, 2'd0, 32'h77);
    cpu_write(1'b0, 2'd2, 32'h3);
    cpu_read(1'b0, 2'd1, d);
    checks++;
    if (io_din !== 32'h8) begin errors++; $display("[TB] FAIL unsel_din_hold: got %h want 00000008", io_din); end
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      if (uart_tx !== 1'b1) lows++;
      tick(1);
    end
    checks++;
    if (lows != 0) begin errors++; $display("[TB] FAIL unsel_no_tx: %0d low clocks, want 0", lows); end
    cpu_read(1'b1, 2'd2, d);
    checks++;
    if (d !== 32'h8) begin errors++; $display("[TB] FAIL unsel_div_kept: got %h want 00000008", d); end
  endtask

  task automatic test_overrun;
    logic [31:0] d;
    int          bad;
    for (int i = 0; i <= DEPTH; i++) send_rx(8'(i + 1), 1'b1, 8);
    cpu_read(1'b1, 2'd1, d);
    checks++;
    if (d !== ((32'(DEPTH) << 8) | 32'hE)) begin
      errors++;
      $display("[TB] FAIL overrun_status: got %h want %h", d, (32'(DEPTH) << 8) | 32'hE);
    end
    cpu_read(1'b1, 2'd1, d);
    checks++;
    if (d !== ((32'(DEPTH) << 8) | 32'h6)) begin
      errors++;
      $display("[TB] FAIL overrun_cleared: got %h want %h", d, (32'(DEPTH) << 8) | 32'h6);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      cpu_read(1'b1, 2'd0, d);
      if (d !== (32'h100 | 32'(i + 1))) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL fifo_order: %0d of %0d bytes wrong", bad, DEPTH); end
    cpu_read(1'b1, 2'd0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL fifo_drained: got %h want 00000000", d); end
  endtask

  task automatic test_framing_glitch;
    logic [31:0] d;
    logic [31:0] want;
    send_rx(8'h5A, 1'b0, 8);
    cpu_read(1'b1, 2'd1, d);
    checks++;
    if (d !== 32'h10) begin errors++; $display("[TB] FAIL framing_set: got %h want 00000010", d); end
    cpu_read(1'b1, 2'd1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL framing_cleared: got %h want 00000000", d); end
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(100);
    cpu_read(1'b1, 2'd1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL glitch_ignored: got %h want 00000000", d); end
    send_rx(8'hC3, 1'b1, 8);
    want = (DEPTH == 1) ? 32'h106 : 32'h102;
    cpu_read(1'b1, 2'd1, d);
    checks++;
    if (d !== want) begin errors++; $display("[TB] FAIL rx_after_glitch_status: got %h want %h", d, want); end
    cpu_read(1'b1, 2'd0, d);
    checks++;
    if (d !== 32'h1C3) begin errors++; $display("[TB] FAIL rx_after_glitch_data: got %h want 000001c3", d); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] d;
    int          lows;
    cpu_read(1'b1, 2'd2, d);
    cpu_write(1'b1, 2'd3, 32'h2);
    cpu_write(1'b1, 2'd0, 32'h00);
    tick(20);
    checks++;
    if (uart_tx !== 1'b0) begin errors++; $display("[TB] FAIL midframe_low: got %b want 0", uart_tx); end
    #2 resetq = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1 || io_din !== 32'h0 || interrupt_request !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: tx=%b din=%h irq=%b want tx=1 din=0 irq=0", uart_tx, io_din, interrupt_request);
    end
    tick(3);
    resetq = 1'b1;
    cpu_read(1'b1, 2'd1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_tx_idle: got %h want 00000000", d); end
    cpu_read(1'b1, 2'd2, d);
    checks++;
    if (d !== 32'd104) begin errors++; $display("[TB] FAIL reset_div_restored: got %h want 00000068", d); end
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      if (uart_tx !== 1'b1 || interrupt_request !== 1'b0) lows++;
      tick(1);
    end
    checks++;
    if (lows != 0) begin errors++; $display("[TB] FAIL reset_quiet: %0d bad clocks, want 0", lows); end
  endtask

  initial begin
    resetq  = 1'b0;
    io_rd   = 1'b0;
    io_wr   = 1'b0;
    io_addr = '0;
    io_dout = '0;
    uart_rx = 1'b1;
    tick(3);
    resetq = 1'b1;
    test_reset;
    test_tx_frame;
    test_tx_busy_ignore;
    test_rx_irq;
    test_div_ie;
    test_unselected;
    test_overrun;
    test_framing_glitch;
    test_reset_midframe;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
